dram_bank_cmd_seq: RTL and testbench

- Sits directly downstream of the DRAM address generator. Consumes one decoded request at a time (rank, bank, RAS, CAS, addr_err) and issues the DDR command sequence (PRE/ACT/RD/WR) needed to service it.
- Tracks open rows for 2 ranks x 8 banks and enforces tRP, tRCD and tRFC.
- Services refresh requests with PREA + REF.
- Feeds the DRAM pad/command-drive stage.

---
 rtl/dram_bank_cmd_seq_if.sv | 31 +++
 rtl/dram_bank_cmd_seq.sv | 273 +++++++++++++++++++++++++++
 tb/tb_dram_bank_cmd_seq.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_bank_cmd_seq_if.sv
// Request / refresh / command / completion bundle between the address generator,
// the bank command sequencer and the pad-drive stage.
interface dram_bank_cmd_seq_if;
    logic        req_vld;
    logic        req_rdy;
    logic        req_wr;
    logic        req_addr_err;
    logic        req_rank;
    logic [2:0]  req_bank;
    logic [14:0] req_ras;
    logic [13:0] req_cas;
    logic        ref_req;
    logic        ref_ack;
    logic        cmd_vld;
    logic [2:0]  cmd_type;
    logic        cmd_rank;
    logic [2:0]  cmd_bank;
    logic [14:0] cmd_addr;
    logic        done_vld;
    logic        done_err;

    modport master (
        output req_vld, req_wr, req_addr_err, req_rank, req_bank, req_ras, req_cas, ref_req,
        input  req_rdy, ref_ack, cmd_vld, cmd_type, cmd_rank, cmd_bank, cmd_addr, done_vld, done_err
    );

    modport slave (
        input  req_vld, req_wr, req_addr_err, req_rank, req_bank, req_ras, req_cas, ref_req,
        output req_rdy, ref_ack, cmd_vld, cmd_type, cmd_rank, cmd_bank, cmd_addr, done_vld, done_err
    );
endinterface

// File: rtl/dram_bank_cmd_seq.sv
// Per-request DDR command sequencer: open-row tracking for 2 ranks x 8 banks,
// tRP/tRCD/tRFC spacing and PREA+REF refresh. Command outputs are registered one cycle ahead.
module dram_bank_cmd_seq #(
    parameter int T_RP  = 3,
    parameter int T_RCD = 3,
    parameter int T_RFC = 20
) (
    input  logic               clk,
    input  logic               rst,
    dram_bank_cmd_seq_if.slave bus
);
    localparam int T_MAX = (T_RFC > T_RP) ? ((T_RFC > T_RCD) ? T_RFC : T_RCD)
                                          : ((T_RP > T_RCD) ? T_RP : T_RCD);
    localparam int TW = $clog2(T_MAX + 1);
    localparam logic [TW-1:0] RP_LOAD  = TW'(T_RP - 1);
    localparam logic [TW-1:0] RCD_LOAD = TW'(T_RCD - 1);
    localparam logic [TW-1:0] RFC_LOAD = TW'(T_RFC - 1);
    localparam logic [TW-1:0] T_ZERO   = {TW{1'b0}};
    localparam logic [TW-1:0] T_ONE    = TW'(1);

    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;
    localparam logic [2:0] CMD_WR   = 3'd3;
    localparam logic [2:0] CMD_PRE  = 3'd4;
    localparam logic [2:0] CMD_PREA = 3'd5;
    localparam logic [2:0] CMD_REF  = 3'd6;

    typedef enum logic [3:0] {
        IDLE = 4'd0, CHK = 4'd1, PRE = 4'd2, WAIT_RP = 4'd3, ACT = 4'd4, WAIT_RCD = 4'd5,
        COL = 4'd6, R_PREA = 4'd7, R_WAIT_RP = 4'd8, R_REF = 4'd9, R_WAIT_RFC = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        W_NONE = 3'd0, W_RP = 3'd1, W_RCD = 3'd2, W_RRP = 3'd3, W_RFC = 3'd4
    } wait_t;

    function automatic logic [2:0] col_cmd(input logic wr);
        return wr ? CMD_WR : CMD_RD;
    endfunction

    state_t        state_r, state_s;
    wait_t         wait_s;
    logic [TW-1:0] timer_r, timer_s;
    logic [15:0]   valid_r;
    logic [14:0]   row_r [16];
    logic          wr_r, rank_r;
    logic [2:0]    bank_r;
    logic [14:0]   ras_r;
    logic [13:0]   cas_r;
    logic          cap_s, tbl_set_s, tbl_clr_s, tbl_clr_all_s;
    logic [3:0]    tbl_idx_s, req_idx_s;
    logic [14:0]   tbl_row_s;
    logic          cmd_vld_r, cmd_vld_s, cmd_rank_r, cmd_rank_s;
    logic [2:0]    cmd_type_r, cmd_type_s, cmd_bank_r, cmd_bank_s;
    logic [14:0]   cmd_addr_r, cmd_addr_s;
    logic          ref_ack_r, ref_ack_s, done_vld_r, done_vld_s, done_err_r, done_err_s;

    assign req_idx_s    = {bus.req_rank, bus.req_bank};
    assign bus.req_rdy  = (state_r == IDLE) && !bus.ref_req && !rst;
    assign bus.cmd_vld  = cmd_vld_r;
    assign bus.cmd_type = cmd_type_r;
    assign bus.cmd_rank = cmd_rank_r;
    assign bus.cmd_bank = cmd_bank_r;
    assign bus.cmd_addr = cmd_addr_r;
    assign bus.ref_ack  = ref_ack_r;
    assign bus.done_vld = done_vld_r;
    assign bus.done_err = done_err_r;

    // Next state plus the command/completion outputs of the cycle being entered.
    always_comb begin
        state_s       = state_r;
        timer_s       = timer_r;
        wait_s        = W_NONE;
        cmd_vld_s     = 1'b0;
        cmd_type_s    = cmd_type_r;
        cmd_rank_s    = cmd_rank_r;
        cmd_bank_s    = cmd_bank_r;
        cmd_addr_s    = cmd_addr_r;
        ref_ack_s     = 1'b0;
        done_vld_s    = 1'b0;
        done_err_s    = 1'b0;
        cap_s         = 1'b0;
        tbl_set_s     = 1'b0;
        tbl_clr_s     = 1'b0;
        tbl_clr_all_s = 1'b0;
        tbl_idx_s     = {rank_r, bank_r};
        tbl_row_s     = ras_r;
        case (state_r)
            IDLE: begin
                if (bus.ref_req) begin
                    cmd_vld_s  = 1'b1;
                    cmd_rank_s = 1'b0;
                    cmd_bank_s = 3'd0;
                    if (|valid_r) begin
                        state_s       = R_PREA;
                        timer_s       = RP_LOAD;
                        cmd_type_s    = CMD_PREA;
                        cmd_addr_s    = 15'h0400;
                        tbl_clr_all_s = 1'b1;
                    end else begin
                        state_s    = R_REF;
                        timer_s    = RFC_LOAD;
                        cmd_type_s = CMD_REF;
                        cmd_addr_s = 15'h0000;
                        ref_ack_s  = 1'b1;
                    end
                end else if (bus.req_vld) begin
                    cap_s     = 1'b1;
                    state_s   = CHK;
                    tbl_idx_s = req_idx_s;
                    tbl_row_s = bus.req_ras;
                    if (bus.req_addr_err) begin
                        done_vld_s = 1'b1;
                        done_err_s = 1'b1;
                    end else begin
                        cmd_vld_s  = 1'b1;
                        cmd_rank_s = bus.req_rank;
                        cmd_bank_s = bus.req_bank;
                        if (valid_r[req_idx_s] && (row_r[req_idx_s] == bus.req_ras)) begin
                            cmd_type_s = col_cmd(bus.req_wr);
                            cmd_addr_s = {1'b0, bus.req_cas};
                            done_vld_s = 1'b1;
                        end else if (valid_r[req_idx_s]) begin
                            cmd_type_s = CMD_PRE;
                            cmd_addr_s = 15'h0000;
                            tbl_clr_s  = 1'b1;
                            timer_s    = RP_LOAD;
                        end else begin
                            cmd_type_s = CMD_ACT;
                            cmd_addr_s = bus.req_ras;
                            tbl_set_s  = 1'b1;
                            timer_s    = RCD_LOAD;
                        end
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CHK: begin
                if (cmd_vld_r && (cmd_type_r == CMD_PRE)) begin
                    wait_s = W_RP;
                end else if (cmd_vld_r && (cmd_type_r == CMD_ACT)) begin
                    wait_s = W_RCD;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_RP:               wait_s  = W_RP;
            ACT, WAIT_RCD:         wait_s  = W_RCD;
            COL:                   state_s = IDLE;
            R_PREA, R_WAIT_RP:     wait_s  = W_RRP;
            R_REF, R_WAIT_RFC:     wait_s  = W_RFC;
            default:               state_s = IDLE;
        endcase

        // Timer reaching zero releases the dependent command into the next cycle.
        case (wait_s)
            W_RP: begin
                if (timer_r == T_ZERO) begin
                    state_s    = ACT;
                    timer_s    = RCD_LOAD;
                    cmd_vld_s  = 1'b1;
                    cmd_type_s = CMD_ACT;
                    cmd_rank_s = rank_r;
                    cmd_bank_s = bank_r;
                    cmd_addr_s = ras_r;
                    tbl_set_s  = 1'b1;
                end else begin
                    state_s = WAIT_RP;
                    timer_s = timer_r - T_ONE;
                end
            end
            W_RCD: begin
                if (timer_r == T_ZERO) begin
                    state_s    = COL;
                    cmd_vld_s  = 1'b1;
                    cmd_type_s = col_cmd(wr_r);
                    cmd_rank_s = rank_r;
                    cmd_bank_s = bank_r;
                    cmd_addr_s = {1'b0, cas_r};
                    done_vld_s = 1'b1;
                end else begin
                    state_s = WAIT_RCD;
                    timer_s = timer_r - T_ONE;
                end
            end
            W_RRP: begin
                if (timer_r == T_ZERO) begin
                    state_s    = R_REF;
                    timer_s    = RFC_LOAD;
                    cmd_vld_s  = 1'b1;
                    cmd_type_s = CMD_REF;
                    cmd_rank_s = 1'b0;
                    cmd_bank_s = 3'd0;
                    cmd_addr_s = 15'h0000;
                    ref_ack_s  = 1'b1;
                end else begin
                    state_s = R_WAIT_RP;
                    timer_s = timer_r - T_ONE;
                end
            end
            W_RFC: begin
                if (timer_r == T_ZERO) begin
                    state_s = IDLE;
                end else begin
                    state_s = R_WAIT_RFC;
                    timer_s = timer_r - T_ONE;
                end
            end
            default: begin
            end
        endcase
    end

    // State, spacing timer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            timer_r    <= T_ZERO;
            cmd_vld_r  <= 1'b0;
            cmd_type_r <= 3'd0;
            cmd_rank_r <= 1'b0;
            cmd_bank_r <= 3'd0;
            cmd_addr_r <= 15'h0000;
            ref_ack_r  <= 1'b0;
            done_vld_r <= 1'b0;
            done_err_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            timer_r    <= timer_s;
            cmd_vld_r  <= cmd_vld_s;
            cmd_type_r <= cmd_type_s;
            cmd_rank_r <= cmd_rank_s;
            cmd_bank_r <= cmd_bank_s;
            cmd_addr_r <= cmd_addr_s;
            ref_ack_r  <= ref_ack_s;
            done_vld_r <= done_vld_s;
            done_err_r <= done_err_s;
        end
    end

    // Accepted request is held for the whole sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_r   <= 1'b0;
            rank_r <= 1'b0;
            bank_r <= 3'd0;
            ras_r  <= 15'h0000;
            cas_r  <= 14'h0000;
        end else if (cap_s) begin
            wr_r   <= bus.req_wr;
            rank_r <= bus.req_rank;
            bank_r <= bus.req_bank;
            ras_r  <= bus.req_ras;
            cas_r  <= bus.req_cas;
        end
    end

    // Open-row table, updated on the edge that launches ACT/PRE/PREA.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 16'h0000;
            for (int i = 0; i < 16; i++) row_r[i] <= 15'h0000;
        end else if (tbl_clr_all_s) begin
            valid_r <= 16'h0000;
        end else if (tbl_clr_s) begin
            valid_r[tbl_idx_s] <= 1'b0;
        end else if (tbl_set_s) begin
            valid_r[tbl_idx_s] <= 1'b1;
            row_r[tbl_idx_s]   <= tbl_row_s;
        end
    end
endmodule

// File: tb/tb_dram_bank_cmd_seq.sv
// Directed bench for dram_bank_cmd_seq: closed bank, hit, miss, addr_err,
// refresh with and without open rows, and reset in the middle of a sequence.
module tb_dram_bank_cmd_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    dram_bank_cmd_seq_if bus();

    dram_bank_cmd_seq #(.T_RP(3), .T_RCD(3), .T_RFC(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_cmd(input string tag, input logic [2:0] t, input logic r,
                              input logic [2:0] b, input logic [14:0] a);
        chk({tag, "_vld"},  32'(bus.cmd_vld),  32'd1);
        chk({tag, "_type"}, 32'(bus.cmd_type), 32'(t));
        chk({tag, "_rank"}, 32'(bus.cmd_rank), 32'(r));
        chk({tag, "_bank"}, 32'(bus.cmd_bank), 32'(b));
        chk({tag, "_addr"}, 32'(bus.cmd_addr), 32'(a));
    endtask

    task automatic expect_nocmd(input string tag);
        chk({tag, "_vld"}, 32'(bus.cmd_vld), 32'd0);
    endtask

    task automatic expect_done(input string tag, input logic v, input logic e);
        chk({tag, "_done_vld"}, 32'(bus.done_vld), 32'(v));
        chk({tag, "_done_err"}, 32'(bus.done_err), 32'(e));
    endtask

    task automatic expect_rdy(input string tag, input logic v);
        chk({tag, "_req_rdy"}, 32'(bus.req_rdy), 32'(v));
    endtask

    task automatic expect_all_zero(input string tag);
        expect_rdy(tag, 1'b0);
        chk({tag, "_cmd_vld"},  32'(bus.cmd_vld),  32'd0);
        chk({tag, "_cmd_type"}, 32'(bus.cmd_type), 32'd0);
        chk({tag, "_cmd_rank"}, 32'(bus.cmd_rank), 32'd0);
        chk({tag, "_cmd_bank"}, 32'(bus.cmd_bank), 32'd0);
        chk({tag, "_cmd_addr"}, 32'(bus.cmd_addr), 32'd0);
        chk({tag, "_ref_ack"},  32'(bus.ref_ack),  32'd0);
        expect_done(tag, 1'b0, 1'b0);
    endtask

    task automatic drive_req(input logic wr, input logic err, input logic rank,
                             input logic [2:0] bank, input logic [14:0] ras, input logic [13:0] cas);
        bus.req_vld      = 1'b1;
        bus.req_wr       = wr;
        bus.req_addr_err = err;
        bus.req_rank     = rank;
        bus.req_bank     = bank;
        bus.req_ras      = ras;
        bus.req_cas      = cas;
    endtask

    // After acceptance the inputs are garbage; the DUT must use its captured copy.
    task automatic scramble();
        bus.req_vld      = 1'b0;
        bus.req_wr       = ~bus.req_wr;
        bus.req_addr_err = 1'b1;
        bus.req_rank     = ~bus.req_rank;
        bus.req_bank     = ~bus.req_bank;
        bus.req_ras      = ~bus.req_ras;
        bus.req_cas      = ~bus.req_cas;
    endtask

    initial begin
        bus.ref_req = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 3'd0, 15'h0000, 14'h0000);
        bus.req_vld = 1'b0;

        repeat (3) tick();
        expect_all_zero("reset");
        rst = 1'b0;
        #1;
        expect_rdy("post_reset", 1'b1);
        expect_nocmd("post_reset");

        // Refresh with an empty table goes straight to REF.
        bus.ref_req = 1'b1;
        #1;
        expect_rdy("ref0_req", 1'b0);
        tick();
        expect_cmd("ref0_ref", 3'd6, 1'b0, 3'd0, 15'h0000);
        chk("ref0_ack", 32'(bus.ref_ack), 32'd1);
        bus.ref_req = 1'b0;
        tick();
        chk("ref0_ack_pulse", 32'(bus.ref_ack), 32'd0);
        expect_nocmd("ref0_after");
        chk("ref0_type_hold", 32'(bus.cmd_type), 32'd6);
        repeat (18) tick();
        expect_rdy("ref0_rfc19", 1'b0);
        tick();
        expect_rdy("ref0_rfc20", 1'b1);

        // Closed bank: ACT, then RD tRCD later.
        drive_req(1'b0, 1'b0, 1'b0, 3'd3, 15'h0123, 14'h0040);
        #1;
        expect_rdy("closed_acc", 1'b1);
        tick();
        scramble();
        expect_cmd("closed_act", 3'd1, 1'b0, 3'd3, 15'h0123);
        expect_done("closed_act", 1'b0, 1'b0);
        expect_rdy("closed_busy", 1'b0);
        tick();
        expect_nocmd("closed_w1");
        tick();
        expect_nocmd("closed_w2");
        tick();
        expect_cmd("closed_rd", 3'd2, 1'b0, 3'd3, 15'h0040);
        expect_done("closed_rd", 1'b1, 1'b0);
        tick();
        expect_rdy("closed_end", 1'b1);
        expect_nocmd("closed_end");
        expect_done("closed_end", 1'b0, 1'b0);

        // Row hit: WR in the CHK cycle.
        drive_req(1'b1, 1'b0, 1'b0, 3'd3, 15'h0123, 14'h0080);
        tick();
        scramble();
        expect_cmd("hit_wr", 3'd3, 1'b0, 3'd3, 15'h0080);
        expect_done("hit_wr", 1'b1, 1'b0);
        tick();
        expect_rdy("hit_end", 1'b1);
        expect_nocmd("hit_end");

        // Row miss: PRE, ACT tRP later, RD tRCD after that.
        drive_req(1'b0, 1'b0, 1'b0, 3'd3, 15'h0456, 14'h0010);
        tick();
        scramble();
        expect_cmd("miss_pre", 3'd4, 1'b0, 3'd3, 15'h0000);
        tick();
        expect_nocmd("miss_w1");
        tick();
        expect_nocmd("miss_w2");
        tick();
        expect_cmd("miss_act", 3'd1, 1'b0, 3'd3, 15'h0456);
        expect_done("miss_act", 1'b0, 1'b0);
        tick();
        expect_nocmd("miss_w3");
        tick();
        expect_nocmd("miss_w4");
        tick();
        expect_cmd("miss_rd", 3'd2, 1'b0, 3'd3, 15'h0010);
        expect_done("miss_rd", 1'b1, 1'b0);
        tick();
        expect_rdy("miss_end", 1'b1);

        // Address error: dropped with done_err, table untouched.
        drive_req(1'b0, 1'b1, 1'b0, 3'd3, 15'h0999, 14'h0000);
        tick();
        scramble();
        expect_nocmd("err_chk");
        expect_done("err_chk", 1'b1, 1'b1);
        tick();
        expect_rdy("err_end", 1'b1);
        expect_done("err_end", 1'b0, 1'b0);
        drive_req(1'b0, 1'b0, 1'b0, 3'd3, 15'h0456, 14'h0011);
        tick();
        scramble();
        expect_cmd("err_hit", 3'd2, 1'b0, 3'd3, 15'h0011);
        expect_done("err_hit", 1'b1, 1'b0);
        tick();

        // Refresh with open rows, request pending at the same time.
        bus.ref_req = 1'b1;
        drive_req(1'b0, 1'b0, 1'b0, 3'd3, 15'h0123, 14'h0020);
        #1;
        expect_rdy("ref1_req", 1'b0);
        tick();
        expect_cmd("ref1_prea", 3'd5, 1'b0, 3'd0, 15'h0400);
        chk("ref1_prea_ack", 32'(bus.ref_ack), 32'd0);
        expect_rdy("ref1_prea", 1'b0);
        tick();
        expect_nocmd("ref1_w1");
        tick();
        expect_nocmd("ref1_w2");
        chk("ref1_w2_ack", 32'(bus.ref_ack), 32'd0);
        tick();
        expect_cmd("ref1_ref", 3'd6, 1'b0, 3'd0, 15'h0000);
        chk("ref1_ack", 32'(bus.ref_ack), 32'd1);
        bus.ref_req = 1'b0;
        repeat (19) tick();
        expect_rdy("ref1_rfc19", 1'b0);
        expect_nocmd("ref1_rfc19");
        tick();
        expect_rdy("ref1_rfc20", 1'b1);
        tick();
        scramble();
        expect_cmd("ref1_act", 3'd1, 1'b0, 3'd3, 15'h0123);
        tick();
        tick();
        tick();
        expect_cmd("ref1_rd", 3'd2, 1'b0, 3'd3, 15'h0020);
        expect_done("ref1_rd", 1'b1, 1'b0);
        tick();

        // Reset during WAIT_RCD abandons the request.
        drive_req(1'b1, 1'b0, 1'b1, 3'd5, 15'h2222, 14'h1234);
        tick();
        scramble();
        expect_cmd("rst_act", 3'd1, 1'b1, 3'd5, 15'h2222);
        tick();
        rst = 1'b1;
        #1;
        expect_all_zero("rst_mid");
        tick();
        expect_done("rst_hold1", 1'b0, 1'b0);
        tick();
        expect_done("rst_hold2", 1'b0, 1'b0);
        expect_nocmd("rst_hold2");
        rst = 1'b0;
        #1;
        expect_rdy("rst_release", 1'b1);
        drive_req(1'b1, 1'b0, 1'b1, 3'd5, 15'h2222, 14'h1234);
        tick();
        scramble();
        expect_cmd("rst_react", 3'd1, 1'b1, 3'd5, 15'h2222);
        tick();
        expect_done("rst_w1", 1'b0, 1'b0);
        tick();
        tick();
        expect_cmd("rst_wr", 3'd3, 1'b1, 3'd5, 15'h1234);
        expect_done("rst_wr", 1'b1, 1'b0);
        tick();
        expect_rdy("rst_end", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
